// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between fetch_ctrl (master) and memory (slave).
interface fetch_ctrl_if #(
   parameter int PC_W    = 36,
   parameter int INSTR_W = 36
);
   logic               o_imem_req;
   logic [PC_W-1:0]    o_imem_addr;
   logic               i_imem_ack;
   logic [INSTR_W-1:0] i_imem_data;

   modport master (output o_imem_req, o_imem_addr, input i_imem_ack, i_imem_data);
   modport slave  (input o_imem_req, o_imem_addr, output i_imem_ack, i_imem_data);
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches over a req/ack bus and presents one instruction to decode.
// Optional macro FETCH_CTRL_PERF_EN adds consumed-instruction and stall-cycle counters.
module fetch_ctrl #(
   parameter int              PC_W     = 36,
   parameter int              INSTR_W  = 36,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              MAX_WAIT = 15
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_stall,
   input  logic               i_redirect,
   input  logic [PC_W-1:0]    i_redirect_pc,
   input  logic               i_halt,
   fetch_ctrl_if.master       imem,
   output logic [PC_W-1:0]    o_pc,
   output logic [INSTR_W-1:0] o_instr,
   output logic [PC_W-1:0]    o_instr_pc,
   output logic               o_instr_valid,
   output logic               o_halted,
`ifdef FETCH_CTRL_PERF_EN
   output logic [31:0]        o_fetch_count,
   output logic [31:0]        o_stall_count,
`endif
   output logic               o_fault
);

   localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   typedef enum logic [2:0] {
      BOOT   = 3'd0,
      FETCH  = 3'd1,
      ISSUE  = 3'd2,
      HALTED = 3'd3,
      FAULT  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
   logic               valid_q, valid_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
         wait_q     <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
         wait_q     <= wait_d;
      end
   end

   // Priority in active states: halt, then redirect, then ack/stall.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
      wait_d     = wait_q;
      case (state_q)
         BOOT: begin
            if (i_halt) begin
               state_d = HALTED;
            end else if (i_redirect) begin
               pc_d    = i_redirect_pc;
               state_d = FETCH;
               wait_d  = '0;
            end else begin
               state_d = FETCH;
               wait_d  = '0;
            end
         end
         FETCH: begin
            if (i_halt) begin
               state_d = HALTED;
               valid_d = 1'b0;
            end else if (i_redirect) begin
               pc_d    = i_redirect_pc;
               wait_d  = '0;
            end else if (imem.i_imem_ack) begin
               instr_d    = imem.i_imem_data;
               instr_pc_d = pc_q;
               valid_d    = 1'b1;
               state_d    = ISSUE;
            end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
               state_d = FAULT;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ISSUE: begin
            if (i_halt) begin
               state_d = HALTED;
               valid_d = 1'b0;
            end else if (i_redirect) begin
               pc_d    = i_redirect_pc;
               valid_d = 1'b0;
               state_d = FETCH;
               wait_d  = '0;
            end else if (i_stall) begin
               state_d = ISSUE;
            end else begin
               pc_d    = pc_q + PC_W'(1);
               valid_d = 1'b0;
               state_d = FETCH;
               wait_d  = '0;
            end
         end
         HALTED: state_d = HALTED;
         FAULT:  state_d = FAULT;
         default: begin
            state_d = FAULT;
            valid_d = 1'b0;
         end
      endcase
   end

`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fetch_cnt_q <= 32'd0;
         stall_cnt_q <= 32'd0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // A consume is an unstalled ISSUE cycle not pre-empted by halt or redirect.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (state_q == ISSUE && !i_halt && !i_redirect && !i_stall) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end else begin
         fetch_cnt_d = fetch_cnt_q;
      end
      if (state_q == ISSUE && i_stall) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   assign o_fetch_count = fetch_cnt_q;
   assign o_stall_count = stall_cnt_q;
`endif

   assign imem.o_imem_req  = (state_q == FETCH);
   assign imem.o_imem_addr = pc_q;
   assign o_pc             = pc_q;
   assign o_instr          = instr_q;
   assign o_instr_pc       = instr_pc_q;
   assign o_instr_valid    = valid_q;
   assign o_halted         = (state_q == HALTED);
   assign o_fault          = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_ctrl;
   localparam int PC_W = 36;
   localparam int INSTR_W = 36;
   localparam int MAX_WAIT = 15;

   logic i_clk = 1'b0;
   logic i_rst, i_stall, i_redirect, i_halt;
   logic [PC_W-1:0] i_redirect_pc;
   logic [PC_W-1:0] o_pc, o_instr_pc;
   logic [INSTR_W-1:0] o_instr;
   logic o_instr_valid, o_halted, o_fault;
`ifdef FETCH_CTRL_PERF_EN
   logic [31:0] o_fetch_count, o_stall_count;
`endif
   int n_pass = 0;
   int n_total = 0;

   // Behavioural model: phase flags rather than a state register.
   logic m_booted, m_valid, m_halted, m_fault;
   int m_waits;
   logic [PC_W-1:0] m_pc, m_ipc;
   logic [INSTR_W-1:0] m_instr;
   logic [31:0] m_fcnt, m_scnt;

   fetch_ctrl_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

   fetch_ctrl #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC('0), .MAX_WAIT(MAX_WAIT)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_redirect(i_redirect),
      .i_redirect_pc(i_redirect_pc), .i_halt(i_halt), .imem(bus.master),
      .o_pc(o_pc), .o_instr(o_instr), .o_instr_pc(o_instr_pc), .o_instr_valid(o_instr_valid),
      .o_halted(o_halted),
`ifdef FETCH_CTRL_PERF_EN
      .o_fetch_count(o_fetch_count), .o_stall_count(o_stall_count),
`endif
      .o_fault(o_fault));

   always #5 i_clk = ~i_clk;

   task automatic model_step();
      logic fetching;
      fetching = m_booted && !m_valid && !m_halted && !m_fault;
      if (i_rst) begin
         m_booted = 1'b0; m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0; m_waits = 0;
         m_pc = '0; m_ipc = '0; m_instr = '0; m_fcnt = 32'd0; m_scnt = 32'd0;
      end else if (m_halted || m_fault) begin
         m_waits = m_waits;
      end else begin
         if (m_valid && i_stall) m_scnt = m_scnt + 32'd1;
         if (i_halt) begin
            m_halted = 1'b1; m_valid = 1'b0;
         end else if (i_redirect) begin
            m_pc = i_redirect_pc; m_valid = 1'b0; m_booted = 1'b1; m_waits = 0;
         end else if (!m_booted) begin
            m_booted = 1'b1; m_waits = 0;
         end else if (m_valid) begin
            if (!i_stall) begin
               m_pc = m_pc + 1; m_valid = 1'b0; m_waits = 0; m_fcnt = m_fcnt + 32'd1;
            end
         end else if (fetching && bus.i_imem_ack) begin
            m_instr = bus.i_imem_data; m_ipc = m_pc; m_valid = 1'b1;
         end else if (m_waits + 1 >= MAX_WAIT) begin
            m_fault = 1'b1;
         end else begin
            m_waits = m_waits + 1;
         end
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_rst = 1'b0; i_stall = 1'b0; i_redirect = 1'b0; i_halt = 1'b0;
      i_redirect_pc = '0; bus.i_imem_ack = 1'b0; bus.i_imem_data = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      i_rst = 1'b1;
      cyc();
      i_rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      i_rst = 1'b1; i_halt = 1'b1; i_redirect = 1'b1; i_redirect_pc = 36'h77; bus.i_imem_ack = 1'b1;
      cyc();
      n_total++; if (o_pc !== 36'd0) $display("FAIL reset_pc got %0h exp 0", o_pc); else n_pass++;
      n_total++; if (o_instr !== 36'd0) $display("FAIL reset_instr got %0h exp 0", o_instr); else n_pass++;
      n_total++; if (o_instr_pc !== 36'd0) $display("FAIL reset_instr_pc got %0h exp 0", o_instr_pc); else n_pass++;
      n_total++; if ({o_instr_valid, o_halted, o_fault, bus.o_imem_req} !== 4'b0000)
         $display("FAIL reset_flags got %b exp 0000", {o_instr_valid, o_halted, o_fault, bus.o_imem_req}); else n_pass++;
      idle_inputs();
      cyc();
      n_total++; if (bus.o_imem_req !== 1'b1) $display("FAIL boot_to_fetch got %b exp 1", bus.o_imem_req); else n_pass++;
   endtask

   task automatic test_stream();
      do_reset();
      bus.i_imem_ack = 1'b1;
      cyc();
      for (int i = 0; i < 3; i++) begin
         bus.i_imem_data = bus.o_imem_addr + 36'h10;
         cyc();
         n_total++; if (o_instr_valid !== 1'b1) $display("FAIL stream_valid_hi got %b exp 1", o_instr_valid); else n_pass++;
         n_total++; if (o_instr !== 36'h10 + 36'(i)) $display("FAIL stream_instr got %0h exp %0h", o_instr, 36'h10 + 36'(i)); else n_pass++;
         n_total++; if (o_instr_pc !== 36'(i)) $display("FAIL stream_instr_pc got %0h exp %0h", o_instr_pc, 36'(i)); else n_pass++;
         cyc();
         n_total++; if (o_instr_valid !== 1'b0) $display("FAIL stream_valid_lo got %b exp 0", o_instr_valid); else n_pass++;
      end
      n_total++; if (o_pc !== 36'd3) $display("FAIL stream_pc got %0h exp 3", o_pc); else n_pass++;
   endtask

   task automatic test_stall();
      do_reset();
      bus.i_imem_ack = 1'b1; bus.i_imem_data = 36'h10;
      cyc();
      cyc();
      i_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.i_imem_data = 36'hABC;
         cyc();
         n_total++; if ({o_instr_valid, o_instr, o_pc} !== {1'b1, 36'h10, 36'd0})
            $display("FAIL stall_hold got v=%b i=%0h pc=%0h exp v=1 i=10 pc=0", o_instr_valid, o_instr, o_pc); else n_pass++;
      end
      i_stall = 1'b0;
      cyc();
      n_total++; if (o_pc !== 36'd1) $display("FAIL stall_release_pc got %0h exp 1", o_pc); else n_pass++;
   endtask

   task automatic test_redirect();
      do_reset();
      cyc();
      i_redirect = 1'b1; i_redirect_pc = 36'h100; bus.i_imem_ack = 1'b1; bus.i_imem_data = 36'hDEAD;
      cyc();
      n_total++; if (o_instr_valid !== 1'b0) $display("FAIL redir_no_capture got %b exp 0", o_instr_valid); else n_pass++;
      n_total++; if ({bus.o_imem_req, bus.o_imem_addr} !== {1'b1, 36'h100})
         $display("FAIL redir_req got req=%b addr=%0h exp req=1 addr=100", bus.o_imem_req, bus.o_imem_addr); else n_pass++;
      i_redirect = 1'b0; bus.i_imem_data = 36'h55;
      cyc();
      n_total++; if ({o_instr_valid, o_instr_pc, o_instr} !== {1'b1, 36'h100, 36'h55})
         $display("FAIL redir_issue got v=%b pc=%0h i=%0h exp v=1 pc=100 i=55", o_instr_valid, o_instr_pc, o_instr); else n_pass++;
   endtask

   task automatic test_timeout();
      int reqs;
      do_reset();
      cyc();
      reqs = 0;
      while (bus.o_imem_req === 1'b1 && reqs < 40) begin
         reqs++;
         cyc();
      end
      n_total++; if (reqs != MAX_WAIT) $display("FAIL timeout_req_cycles got %0d exp %0d", reqs, MAX_WAIT); else n_pass++;
      n_total++; if ({o_fault, bus.o_imem_req, o_pc} !== {1'b1, 1'b0, 36'd0})
         $display("FAIL timeout_fault got f=%b req=%b pc=%0h exp f=1 req=0 pc=0", o_fault, bus.o_imem_req, o_pc); else n_pass++;
      bus.i_imem_ack = 1'b1; i_redirect = 1'b1; i_redirect_pc = 36'h33;
      cyc(); cyc();
      n_total++; if ({o_fault, o_instr_valid, bus.o_imem_req, o_pc} !== {1'b1, 1'b0, 1'b0, 36'd0})
         $display("FAIL fault_sticky got f=%b v=%b req=%b pc=%0h exp f=1 v=0 req=0 pc=0", o_fault, o_instr_valid, bus.o_imem_req, o_pc); else n_pass++;
      do_reset();
      n_total++; if (o_fault !== 1'b0) $display("FAIL fault_cleared got %b exp 0", o_fault); else n_pass++;
   endtask

   task automatic test_halt();
      do_reset();
      i_redirect = 1'b1; i_redirect_pc = 36'd5;
      cyc();
      i_redirect = 1'b0; bus.i_imem_ack = 1'b1; bus.i_imem_data = 36'h99;
      cyc();
      n_total++; if ({o_instr_valid, o_instr_pc} !== {1'b1, 36'd5}) $display("FAIL halt_setup got v=%b pc=%0h exp v=1 pc=5", o_instr_valid, o_instr_pc); else n_pass++;
      i_halt = 1'b1;
      cyc();
      i_halt = 1'b0;
      n_total++; if ({o_halted, o_instr_valid, bus.o_imem_req, o_pc} !== {1'b1, 1'b0, 1'b0, 36'd5})
         $display("FAIL halt_enter got h=%b v=%b req=%b pc=%0h exp h=1 v=0 req=0 pc=5", o_halted, o_instr_valid, bus.o_imem_req, o_pc); else n_pass++;
      i_redirect = 1'b1; i_redirect_pc = 36'h40;
      cyc(); cyc();
      n_total++; if ({o_halted, bus.o_imem_req, o_pc} !== {1'b1, 1'b0, 36'd5})
         $display("FAIL halt_ignores_redir got h=%b req=%b pc=%0h exp h=1 req=0 pc=5", o_halted, bus.o_imem_req, o_pc); else n_pass++;
      do_reset();
      n_total++; if ({o_halted, o_pc} !== {1'b0, 36'd0}) $display("FAIL halt_reset got h=%b pc=%0h exp h=0 pc=0", o_halted, o_pc); else n_pass++;
   endtask

   task automatic test_wrap();
      do_reset();
      i_redirect = 1'b1; i_redirect_pc = '1;
      cyc();
      i_redirect = 1'b0; bus.i_imem_ack = 1'b1; bus.i_imem_data = 36'h7;
      cyc();
      cyc();
      n_total++; if (o_pc !== 36'd0) $display("FAIL wrap_pc got %0h exp 0", o_pc); else n_pass++;
`ifdef FETCH_CTRL_PERF_EN
      n_total++; if (o_fetch_count !== 32'd1) $display("FAIL wrap_fetch_count got %0d exp 1", o_fetch_count); else n_pass++;
`endif
   endtask

   task automatic test_random();
      int ack_pct;
      logic [63:0] r;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         ack_pct = ((c / 150) % 2 == 0) ? 60 : 4;
         r = {$urandom(), $urandom()};
         i_rst = ($urandom_range(0, 99) < 2);
         i_halt = ($urandom_range(0, 99) < 2);
         i_redirect = ($urandom_range(0, 99) < 10);
         i_redirect_pc = r[PC_W-1:0];
         i_stall = ($urandom_range(0, 99) < 35);
         bus.i_imem_ack = ($urandom_range(0, 99) < ack_pct);
         r = {$urandom(), $urandom()};
         bus.i_imem_data = r[INSTR_W-1:0];
         cyc();
         n_total++;
         if ({o_pc, o_instr, o_instr_pc, o_instr_valid, o_halted, o_fault, bus.o_imem_req, bus.o_imem_addr} !==
             {m_pc, m_instr, m_ipc, m_valid, m_halted, m_fault, (m_booted && !m_valid && !m_halted && !m_fault), m_pc})
            $display("FAIL rand_c%0d got pc=%0h i=%0h ipc=%0h v=%b h=%b f=%b req=%b exp pc=%0h i=%0h ipc=%0h v=%b h=%b f=%b",
                     c, o_pc, o_instr, o_instr_pc, o_instr_valid, o_halted, o_fault, bus.o_imem_req,
                     m_pc, m_instr, m_ipc, m_valid, m_halted, m_fault);
         else n_pass++;
`ifdef FETCH_CTRL_PERF_EN
         n_total++; if ({o_fetch_count, o_stall_count} !== {m_fcnt, m_scnt})
            $display("FAIL rand_perf_c%0d got f=%0d s=%0d exp f=%0d s=%0d", c, o_fetch_count, o_stall_count, m_fcnt, m_scnt); else n_pass++;
`endif
      end
   endtask

   initial begin
      idle_inputs();
      #1;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_timeout();
      test_halt();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the program counter and moves it through fetch, issue, redirect and halt.
- Issues word-addressed requests to instruction memory over a req/ack handshake and presents one fetched instruction at a time to decode.
- Honours stall, redirect (branch/jump) and halt from downstream, and flags memory that never acknowledges.

Parameters:
- PC_W, 36, program counter and instruction-memory address width.
- INSTR_W, 36, instruction word width.
- RESET_PC, 0, PC value loaded on reset.
- MAX_WAIT, 15, maximum unacknowledged FETCH cycles before fault (must be ≥ 1).

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_stall  input  1  decode cannot accept the presented instruction this cycle.
- i_redirect  input  1  load i_redirect_pc as the new PC.
- i_redirect_pc  input  PC_W  redirect target.
- i_halt  input  1  stop fetching permanently until reset.
- o_imem_req  output  1  fetch request; equals (state==FETCH).
- o_imem_addr  output  PC_W  request address; always equals o_pc.
- i_imem_ack  input  1  memory returns data this cycle.
- i_imem_data  input  INSTR_W  instruction word, valid when ack=1.
- o_pc  output  PC_W  current PC register.
- o_instr  output  INSTR_W  captured instruction.
- o_instr_pc  output  PC_W  PC of o_instr.
- o_instr_valid  output  1  o_instr is presented to decode.
- o_halted  output  1  in HALTED state.
- o_fault  output  1  sticky fetch-timeout flag.

Behaviour:
- Reset values:
  - state=BOOT, o_pc=RESET_PC, o_instr=0, o_instr_pc=0, o_instr_valid=0, o_halted=0, o_fault=0, wait counter=0.
  - i_rst overrides every other input, in every state.
- States:
  - BOOT: no request. Next edge goes to FETCH.
  - FETCH: o_imem_req=1.
    - On i_imem_ack: o_instr<=i_imem_data, o_instr_pc<=o_pc, o_instr_valid<=1, go to ISSUE.
    - Without ack: wait counter increments. After MAX_WAIT consecutive unacked cycles, go to FAULT on the next edge.
    - An ack in cycle k (1..MAX_WAIT) is accepted.
    - Wait counter clears on every FETCH entry.
  - ISSUE: o_instr_valid=1 and o_instr held stable.
    - i_stall=1: hold everything.
    - i_stall=0: instruction consumed this cycle; o_pc<=o_pc+1 modulo 2^PC_W; o_instr_valid<=0; go to FETCH.
  - HALTED: req=0, valid=0, o_halted=1, o_pc held. Exit only via reset.
  - FAULT: req=0, valid=0, o_fault=1, o_pc held. Exit only via reset.
- Latency and throughput:
  - With ack in the same cycle as req, data appears on o_instr_valid one cycle after ack.
  - Steady-state throughput is one instruction per 2 cycles (FETCH, ISSUE).
- Priority within a cycle (BOOT/FETCH/ISSUE): i_rst > i_halt > i_redirect > ack/stall.
  - i_halt: go to HALTED next edge; o_instr_valid<=0; PC unchanged; any same-cycle ack discarded.
  - i_redirect: o_pc<=i_redirect_pc, o_instr_valid<=0, go to FETCH.
    - A same-cycle ack is discarded.
    - A presented instruction is dropped, even if i_stall=0.
    - Redirect in BOOT also goes to FETCH.
- i_redirect and i_halt are ignored in HALTED and FAULT.
- i_stall is ignored outside ISSUE.
- i_imem_ack is ignored outside FETCH.
- o_imem_req and o_imem_addr are combinational decodes of registered state only; no input-to-output combinational path.

Optional Feature:
- Macro: FETCH_CTRL_PERF_EN.
- When defined, adds two outputs:
  - o_fetch_count (32 bit): increments on each consumed instruction (ISSUE with i_stall=0 and no halt/redirect).
  - o_stall_count (32 bit): increments each ISSUE cycle with i_stall=1.
  - Both reset to 0 and wrap at 2^32.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then ack tied 1 and stall tied 0, imem_data=PC+0x10:
  - valid pulses on alternate cycles with o_instr 0x10, 0x11, 0x12.
  - o_pc=3 after three consumes.
- Hold i_stall=1 for 4 cycles in ISSUE at PC 0:
  - o_instr_valid stays 1, o_instr unchanged, o_pc=0.
  - After stall drops, o_pc=1 next cycle.
- i_redirect=1 with i_redirect_pc=0x100 in the same FETCH cycle as an ack:
  - data is not captured; next req has o_imem_addr=0x100.
  - o_instr_pc=0x100 on the following issue.
- i_imem_ack held 0 with MAX_WAIT=15:
  - req stays 1 for exactly 15 cycles, then o_fault=1 and req=0, o_pc held.
  - A later ack or redirect has no effect; reset clears the fault.
- i_halt=1 during ISSUE at PC 5:
  - o_halted=1 next cycle, req=0 thereafter, o_pc=5.
  - A redirect to 0x40 is ignored; reset returns o_pc to 0.
- Redirect to 2^36-1, ack, consume:
  - o_pc wraps to 0.
  - With FETCH_CTRL_PERF_EN, o_fetch_count=1.
